// File: rtl/dmi_initiator.sv
// dmi_initiator: DTM-side DMI master. Turns JTAG DR updates into dm::dmi_req_t
// transactions, collects dm::dmi_resp_t responses and builds the captured DR
// value with read data and a sticky operation status.

package dm;

  typedef enum logic [1:0] {
    DTM_NOP   = 2'h0,
    DTM_READ  = 2'h1,
    DTM_WRITE = 2'h2,
    DTM_RSVD  = 2'h3
  } dtm_op_t;

  localparam logic [1:0] DTM_SUCCESS = 2'h0;
  localparam logic [1:0] DTM_ERR     = 2'h2;
  localparam logic [1:0] DTM_BUSY    = 2'h3;

  typedef struct packed {
    logic [6:0]  addr;
    dtm_op_t     op;
    logic [31:0] data;
  } dmi_req_t;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } dmi_resp_t;

endpackage

module dmi_initiator (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         update_i,
  input  logic [40:0]  dr_i,
  input  logic         capture_i,
  output logic [40:0]  dr_o,
  input  logic         dmireset_i,
  input  logic         dmihardreset_i,
  output logic         busy_o,
  output logic [1:0]   error_o,
  output logic         dmi_req_valid_o,
  input  logic         dmi_req_ready_i,
  output dm::dmi_req_t dmi_req_o,
  input  logic         dmi_resp_valid_i,
  output logic         dmi_resp_ready_o,
  input  dm::dmi_resp_t dmi_resp_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [6:0]  addr_q, addr_d;
  logic [31:0] data_q, data_d;
  dm::dtm_op_t op_q, op_d;
  logic [1:0]  error_q, error_d;
  logic [40:0] dr_q, dr_d;

  logic        isIdle;
  logic [1:0]  errCleared;
  logic [1:0]  captureStatus;
  dm::dtm_op_t updateOp;
  logic        newReq;
  logic        respFire;

  // dmireset takes effect before the update is judged, so the error seen by
  // the update path is the post-clear value; capture still reports the old one.
  assign isIdle        = (state_q == IDLE);
  assign errCleared    = dmireset_i ? 2'd0 : error_q;
  assign captureStatus = isIdle ? error_q : dm::DTM_BUSY;
  assign updateOp      = dm::dtm_op_t'(dr_i[1:0]);
  assign newReq        = update_i && isIdle && (errCleared == 2'd0) && !dmihardreset_i &&
                         ((updateOp == dm::DTM_READ) || (updateOp == dm::DTM_WRITE));
  assign respFire      = (state_q == WAIT) && dmi_resp_valid_i;

  // State register; hard reset and async reset both land in IDLE.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: issue, wait for acceptance, wait for the response.
  always_comb begin
    state_d = state_q;
    if (dmihardreset_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (newReq)           state_d = REQ;
        REQ:     if (dmi_req_ready_i)  state_d = WAIT;
        WAIT:    if (dmi_resp_valid_i) state_d = IDLE;
        default:                       state_d = IDLE;
      endcase
    end
  end

  // Outputs decoded purely from registered state, no input-to-output paths.
  always_comb begin
    busy_o           = !isIdle;
    dmi_req_valid_o  = (state_q == REQ);
    dmi_resp_ready_o = (state_q != REQ);
    error_o          = error_q;
    dr_o             = dr_q;
    dmi_req_o        = {addr_q, op_q, data_q};
  end

  // Datapath next values: capture sees pre-update/pre-response values, busy
  // errors are recorded before response failures, and a non-zero status is
  // never replaced by a different one.
  always_comb begin
    addr_d  = addr_q;
    data_d  = data_q;
    op_d    = op_q;
    dr_d    = dr_q;
    error_d = errCleared;
    if (dmihardreset_i) begin
      error_d = 2'd0;
    end else begin
      if (capture_i) begin
        dr_d = {addr_q, data_q, captureStatus};
      end
      if (!isIdle && (capture_i || update_i) && (error_d == 2'd0)) begin
        error_d = dm::DTM_BUSY;
      end
      if (newReq) begin
        addr_d = dr_i[40:34];
        data_d = dr_i[33:2];
        op_d   = updateOp;
      end
      if (respFire) begin
        if (op_q == dm::DTM_READ) begin
          data_d = dmi_resp_i.data;
        end
        if ((dmi_resp_i.resp != dm::DTM_SUCCESS) && (error_d == 2'd0)) begin
          error_d = dm::DTM_ERR;
        end
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_q  <= 7'd0;
      data_q  <= 32'd0;
      op_q    <= dm::DTM_NOP;
      error_q <= 2'd0;
      dr_q    <= 41'd0;
    end else begin
      addr_q  <= addr_d;
      data_q  <= data_d;
      op_q    <= op_d;
      error_q <= error_d;
      dr_q    <= dr_d;
    end
  end

endmodule
